pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles spent waiting for dmem_ack_i before abort; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk_i  input  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 ID_EX_MemRead_i  input  1  instruction in EX is a load.
REQ-006 ID_EX_RegisterRt_i  input  5  load destination register in EX.
REQ-007 IF_ID_RS_i / IF_ID_RT_i  input  5 each  source registers of the instruction in ID.
REQ-008 branch_taken_i  input  1  branch in ID resolved taken this cycle.
REQ-009 dmem_req_i  input  1  MEM stage issues a data-memory access this cycle.
REQ-010 dmem_ack_i  input  1  data memory completes the access this cycle.
REQ-011 PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o  output  1 each  stage-register enables.
REQ-012 ctrl_bubble_o  output  1  1 = zero ID control signals into ID/EX.
REQ-013 IF_ID_flush_o  output  1  clear IF/ID to NOP.
REQ-014 mem_err_o  output  1  one-cycle pulse on memory timeout.
REQ-015 state_o  output  2  current FSM state, for debug.

Function
REQ-016 FSM states RUN, MEM_WAIT; state and timeout counter registered, all enables/bubble/flush combinational from state and inputs.
REQ-017 Load-use hazard = ID_EX_MemRead_i & ID_EX_RegisterRt_i != 0 & (Rt == IF_ID_RS_i | Rt == IF_ID_RT_i).
REQ-018 Memory stall = dmem_req_i & ~dmem_ack_i.
REQ-019 Priority per cycle: memory stall > load-use hazard > branch flush > normal.
REQ-020 Memory stall (RUN or MEM_WAIT): all five enables 0, bubble 0, flush 0; RUN moves to MEM_WAIT.
REQ-021 MEM_WAIT: timeout counter increments each cycle; dmem_ack_i high -> all enables 1 that cycle, return to RUN, counter cleared.
REQ-022 Counter reaching MEM_TIMEOUT-1 without ack -> mem_err_o pulse, all enables 1 that cycle, return to RUN, counter cleared.
REQ-023 Load-use hazard in RUN: PC_write_o=0, IF_ID_write_o=0, ctrl_bubble_o=1, downstream enables 1; exactly one bubble per hazard.
REQ-024 branch_taken_i ignored while load-use hazard is true (operands not yet valid); re-evaluated next cycle.
REQ-025 Branch flush in RUN: IF_ID_flush_o=1 for one cycle, all enables 1, bubble 0.
REQ-026 Normal: all enables 1, bubble 0, flush 0.
REQ-027 Same-cycle load-use and branch -> stall only; branch during memory stall -> no flush until memory stall ends.

Reset
REQ-028 rst_i high at clock edge -> state RUN, timeout counter 0, perf counters 0, mem_err_o 0, regardless of current state (including mid MEM_WAIT).
REQ-029 While rst_i high, outputs take RUN/normal values: enables 1, bubble 0, flush 0.

Configuration
REQ-030 Macro PIPE_STALL_CTRL_PERF_EN defined -> outputs stall_cnt_o and flush_cnt_o (CNT_W each) count cycles with PC_write_o=0 and cycles with IF_ID_flush_o=1, saturating at all-ones.
REQ-031 Macro undefined -> those ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package pipe_ctrl_pkg holds FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1) and register-index width constant (5).
REQ-033 One sub-module sat_counter (parameter width, inc, clear) instantiated twice for perf counters; timeout counter inline.

Verification
REQ-034 Load to $t1 in EX, ID uses RS=$t1 -> one cycle PC_write_o=0, IF_ID_write_o=0, ctrl_bubble_o=1, then normal.
REQ-035 Load to $zero with RS=0 in ID -> no stall, all enables 1.
REQ-036 Load-use hazard and branch_taken_i same cycle -> stall only, no flush; next cycle branch_taken_i -> IF_ID_flush_o=1.
REQ-037 dmem_req_i held, ack after 3 cycles -> enables 0 for 3 cycles, state_o=MEM_WAIT, resume on ack cycle.
REQ-038 dmem_req_i held, no ack, MEM_TIMEOUT=4 -> mem_err_o pulse in 4th stalled cycle, state_o=RUN next.
REQ-039 rst_i asserted mid MEM_WAIT -> next cycle state_o=RUN, enables 1, perf counters 0 (with PIPE_STALL_CTRL_PERF_EN).

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: FSM encoding and register-index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;

    // A load in EX whose destination (other than $zero) is read by the instruction in ID.
    function automatic logic load_use_hazard(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] ex_rt,
        input logic [REG_IDX_W-1:0] id_rs,
        input logic [REG_IDX_W-1:0] id_rt
    );
        return mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of hazard status inputs and stage-register controls between pipeline and stall controller.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller itself is the pipeline's backpressure source.
interface pipe_stall_ctrl_if;
    import pipe_ctrl_pkg::*;

    // Pipeline status into the controller
    logic                 ID_EX_MemRead_i;
    logic [REG_IDX_W-1:0] ID_EX_RegisterRt_i;
    logic [REG_IDX_W-1:0] IF_ID_RS_i;
    logic [REG_IDX_W-1:0] IF_ID_RT_i;
    logic                 branch_taken_i;
    logic                 dmem_req_i;
    logic                 dmem_ack_i;

    // Controls back to the pipeline
    logic                 PC_write_o;
    logic                 IF_ID_write_o;
    logic                 ID_EX_write_o;
    logic                 EX_MEM_write_o;
    logic                 MEM_WB_write_o;
    logic                 ctrl_bubble_o;
    logic                 IF_ID_flush_o;
    logic                 mem_err_o;
    logic [STATE_W-1:0]   state_o;

    // Pipeline side: reports hazards, obeys controls
    modport master (
        output ID_EX_MemRead_i, ID_EX_RegisterRt_i, IF_ID_RS_i, IF_ID_RT_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o,
               ctrl_bubble_o, IF_ID_flush_o, mem_err_o, state_o
    );

    // Controller side
    modport slave (
        input  ID_EX_MemRead_i, ID_EX_RegisterRt_i, IF_ID_RS_i, IF_ID_RT_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o,
               ctrl_bubble_o, IF_ID_flush_o, mem_err_o, state_o
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating event counter (sat_counter): counts cycles with inc_i high, sticks at all-ones.
// Latency: count visible the cycle after the event; clear_i takes effect on the next edge.
// Backpressure: none; never stalls, simply stops advancing at saturation.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory-wait stall with timeout, load-use bubble, branch flush.
// Latency: all controls combinational from state and inputs; state/timeout registered (1 cycle).
// Backpressure: drops stage-register enables on memory stall or load-use hazard; optional perf
// counters built when PIPE_STALL_CTRL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_stall_ctrl_if.slave ctl
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    // Elaboration-time parameter sanity
    if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_bad_mem_timeout
        $error("pipe_stall_ctrl: MEM_TIMEOUT must be in 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W must be at least 1");
    end

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;

    logic hazard;
    logic mem_stall;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic bubble, flush, mem_err;

    assign hazard    = load_use_hazard(ctl.ID_EX_MemRead_i, ctl.ID_EX_RegisterRt_i,
                                       ctl.IF_ID_RS_i, ctl.IF_ID_RT_i);
    assign mem_stall = ctl.dmem_req_i & ~ctl.dmem_ack_i;

    // Next state, timeout count and all stage controls, in priority order:
    // memory stall > load-use > branch flush > normal.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        exmem_we  = 1'b1;
        memwb_we  = 1'b1;
        bubble    = 1'b0;
        flush     = 1'b0;
        mem_err   = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                if (ctl.dmem_ack_i) begin
                    // Access completes: whole pipe advances this cycle
                    state_d   = ST_RUN;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up on the access, flag it and let the pipe move on
                    mem_err   = 1'b1;
                    state_d   = ST_RUN;
                    tmo_cnt_d = '0;
                end else begin
                    // Still waiting: freeze everything, including any pending branch
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                if (mem_stall) begin
                    // First stalled cycle is counted here so the timeout covers it
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                    state_d   = ST_MEM_WAIT;
                    tmo_cnt_d = 8'd1;
                end else if (hazard) begin
                    // Hold IF and ID, inject one bubble; the bubble clears MemRead in EX so
                    // the hazard drops next cycle. A branch here waits for valid operands.
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    bubble  = 1'b1;
                end else if (ctl.branch_taken_i) begin
                    flush = 1'b1;
                end
            end
        endcase

        // Reset cycles present plain RUN behaviour to the pipeline
        if (rst_i) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            bubble   = 1'b0;
            flush    = 1'b0;
            mem_err  = 1'b0;
        end
    end

    // FSM state and timeout counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign ctl.PC_write_o     = pc_we;
    assign ctl.IF_ID_write_o  = ifid_we;
    assign ctl.ID_EX_write_o  = idex_we;
    assign ctl.EX_MEM_write_o = exmem_we;
    assign ctl.MEM_WB_write_o = memwb_we;
    assign ctl.ctrl_bubble_o  = bubble;
    assign ctl.IF_ID_flush_o  = flush;
    assign ctl.mem_err_o      = mem_err;
    assign ctl.state_o        = state_q;

`ifdef PIPE_STALL_CTRL_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (~pc_we),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (flush),
        .cnt_o   (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MEM_TIMEOUT=4 and 3-bit perf counters.
// Inputs are driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Perf-counter checks are built only when PIPE_STALL_CTRL_PERF_EN is defined.
module tb_pipe_stall_ctrl;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    pipe_stall_ctrl_if pif ();

`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [2:0] stall_cnt;
    logic [2:0] flush_cnt;
`endif

    pipe_stall_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (3)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ctl   (pif.slave)
`ifdef PIPE_STALL_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
    task automatic check_out(input string tag, input logic [4:0] en, input logic bub,
                             input logic fl);
        chk({tag, "_en"}, {27'd0, pif.PC_write_o, pif.IF_ID_write_o, pif.ID_EX_write_o,
                           pif.EX_MEM_write_o, pif.MEM_WB_write_o}, {27'd0, en});
        chk({tag, "_bubble"}, {31'd0, pif.ctrl_bubble_o}, {31'd0, bub});
        chk({tag, "_flush"}, {31'd0, pif.IF_ID_flush_o}, {31'd0, fl});
    endtask

    task automatic check_perf(input string tag, input logic [2:0] st, input logic [2:0] fc);
`ifdef PIPE_STALL_CTRL_PERF_EN
        chk({tag, "_stall_cnt"}, {29'd0, stall_cnt}, {29'd0, st});
        chk({tag, "_flush_cnt"}, {29'd0, flush_cnt}, {29'd0, fc});
`else
        if (st === fc) begin end
        if (tag.len() == 0) begin end
`endif
    endtask

    // One clock cycle of stimulus: apply after the edge, return at the falling edge
    task automatic step(input logic rst, input logic mr, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic req, input logic ack);
        @(posedge clk_i);
        #1;
        rst_i                  = rst;
        pif.ID_EX_MemRead_i    = mr;
        pif.ID_EX_RegisterRt_i = ex_rt;
        pif.IF_ID_RS_i         = rs;
        pif.IF_ID_RT_i         = rt;
        pif.branch_taken_i     = br;
        pif.dmem_req_i         = req;
        pif.dmem_ack_i         = ack;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i                  = 1'b1;
        pif.ID_EX_MemRead_i    = 1'b0;
        pif.ID_EX_RegisterRt_i = '0;
        pif.IF_ID_RS_i         = '0;
        pif.IF_ID_RT_i         = '0;
        pif.branch_taken_i     = 1'b0;
        pif.dmem_req_i         = 1'b0;
        pif.dmem_ack_i         = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_state", {30'd0, pif.state_o}, 32'd0);
        chk("rst_err", {31'd0, pif.mem_err_o}, 32'd0);
        check_out("rst", 5'h1f, 0, 0);
        check_perf("rst", 3'd0, 3'd0);

        // Hazard, branch and memory stall all ignored while reset is high
        step(1, 1, 9, 9, 0, 1, 1, 0);
        check_out("rst_busy", 5'h1f, 0, 0);

        // Normal
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("norm_state", {30'd0, pif.state_o}, 32'd0);
        check_out("norm", 5'h1f, 0, 0);

        // Branch alone flushes
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check_out("br", 5'h1f, 0, 1);

        // Load to $t1 (9), RS=$t1: one bubble, then normal
        step(0, 1, 9, 9, 3, 0, 0, 0);
        check_out("lu_rs", 5'b00111, 1, 0);
        step(0, 0, 9, 9, 3, 0, 0, 0);
        check_out("lu_after", 5'h1f, 0, 0);
        check_perf("lu_after", 3'd1, 3'd1);

        // Match on RT only
        step(0, 1, 12, 4, 12, 0, 0, 0);
        check_out("lu_rt", 5'b00111, 1, 0);

        // Load destination matches neither source
        step(0, 1, 12, 4, 5, 0, 0, 0);
        check_out("no_lu", 5'h1f, 0, 0);

        // Load to $zero with RS=$zero
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check_out("lu_zero", 5'h1f, 0, 0);

        // Load-use with branch: stall only; branch taken the next cycle flushes
        step(0, 1, 7, 2, 7, 1, 0, 0);
        check_out("lu_br", 5'b00111, 1, 0);
        step(0, 0, 7, 2, 7, 1, 0, 0);
        check_out("br_after", 5'h1f, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_out("idle1", 5'h1f, 0, 0);
        check_perf("idle1", 3'd3, 3'd2);

        // Memory stall for 3 cycles (with hazard+branch present early), ack on the 4th
        step(0, 1, 7, 2, 7, 1, 1, 0);
        check_out("ms1", 5'h00, 0, 0);
        chk("ms1_state", {30'd0, pif.state_o}, 32'd0);
        step(0, 1, 7, 2, 7, 1, 1, 0);
        check_out("ms2", 5'h00, 0, 0);
        chk("ms2_state", {30'd0, pif.state_o}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check_out("ms3", 5'h00, 0, 0);
        chk("ms3_state", {30'd0, pif.state_o}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        check_out("ms_ack", 5'h1f, 0, 0);
        chk("ms_ack_err", {31'd0, pif.mem_err_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ms_done_state", {30'd0, pif.state_o}, 32'd0);
        check_out("ms_done", 5'h1f, 0, 0);
        check_perf("ms_done", 3'd6, 3'd2);

        // Timeout: no ack, error pulse in 4th stalled cycle
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("tmo%0d_err", i), {31'd0, pif.mem_err_o}, {31'd0, (i == 3)});
            check_out($sformatf("tmo%0d", i), (i == 3) ? 5'h1f : 5'h00, 0, 0);
            chk($sformatf("tmo%0d_state", i), {30'd0, pif.state_o}, (i == 0) ? 32'd0 : 32'd1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo_done_state", {30'd0, pif.state_o}, 32'd0);
        chk("tmo_done_err", {31'd0, pif.mem_err_o}, 32'd0);
        check_perf("tmo_sat", 3'd7, 3'd2);

        // Reset in the middle of MEM_WAIT
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mrst_wait_state", {30'd0, pif.state_o}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        check_out("mrst_hold", 5'h1f, 0, 0);
        chk("mrst_hold_err", {31'd0, pif.mem_err_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mrst_state", {30'd0, pif.state_o}, 32'd0);
        check_out("mrst", 5'h1f, 0, 0);
        check_perf("mrst", 3'd0, 3'd0);

        // Timeout counter restarts from zero after that reset
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("tmo2_%0d_err", i), {31'd0, pif.mem_err_o}, {31'd0, (i == 3)});
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo2_done_state", {30'd0, pif.state_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
